// File: rtl/riscv_ctrl_fsm.sv
// riscv_ctrl_fsm
// Multi-cycle control unit for the RV32I subset datapath. Sequences every
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives all datapath
// control inputs. It supports R-type ALU ops, I-type ALU ops, LW, SW and
// BEQ/BNE/BLT/BGE. Any other encoding either traps or retires as a NOP,
// depending on TRAP_ON_ILLEGAL.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   instr        instruction word from ROM, stable while pc_we=0
//   status       ALU flags: [4]=Z [3]=N [2]=V [1]=C [0]=P
//   pcsrc        0 = PC+4, 1 = PC+imm (combinational from status in EXEC of a branch)
//   alusrc       0 = rs2, 1 = immediate
//   aluop        ALU operation select
//   memrw        1 = RAM write, 0 = read
//   wb           writeback select: 0 = RAM data, 1 = ALU result
//   regrw        register file write enable
//   immgen_ctrl  immediate format: 00 none, 01 I, 10 S, 11 B
//   pc_we        PC load enable, one pulse per retired instruction
//   ir_we        instruction register load enable
//   state        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   illegal      sticky illegal-instruction flag
//   instret      retired-instruction count, wraps silently
module riscv_ctrl_fsm #(
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [4:0]       status,
    output logic             pcsrc,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             memrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic             pc_we,
    output logic             ir_we,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LW = 3'd2,
        CLS_SW = 3'd3,
        CLS_BR = 3'd4
    } cls_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_S    = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t           state_q;
    cls_t             cls_q;
    logic [2:0]       br_f3_q;
    logic             nop_q;
    logic             alusrc_q, memrw_q, wb_q, regrw_q, pc_we_q, ir_we_q, illegal_q;
    logic [3:0]       aluop_q;
    logic [1:0]       immgen_q;
    logic [CNT_W-1:0] instret_q;

    cls_t       dec_cls;
    logic [3:0] dec_aluop;
    logic       dec_legal;
    logic       taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    // Register specifiers, rd and the carry/parity flags are consumed by
    // the datapath, not by this controller.
    logic unused_inputs;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_inputs = ^{instr[24:15], instr[11:7], status[1:0]};

    // Instruction decoder. For I-type ALU ops the upper bits are immediate,
    // so funct7 is only checked for the shift-immediate forms.
    always_comb begin
        dec_cls   = CLS_R;
        dec_aluop = ALU_ADD;
        dec_legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_cls = CLS_R;
                if (funct7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_aluop = ALU_ADD;
                        3'b001:  dec_aluop = ALU_SLL;
                        3'b010:  dec_aluop = ALU_SLT;
                        3'b011:  dec_aluop = ALU_SLTU;
                        3'b100:  dec_aluop = ALU_XOR;
                        3'b101:  dec_aluop = ALU_SRL;
                        3'b110:  dec_aluop = ALU_OR;
                        default: dec_aluop = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_aluop = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_aluop = ALU_SRA;
                    end
                end
            end
            7'b0010011: begin
                dec_cls = CLS_I;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_aluop = ALU_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_aluop = ALU_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_aluop = ALU_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_aluop = ALU_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_aluop = ALU_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_aluop = ALU_AND;  end
                    3'b001: begin
                        dec_legal = (funct7 == F7_ZERO);
                        dec_aluop = ALU_SLL;
                    end
                    default: begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_aluop = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            7'b0000011: begin
                dec_cls   = CLS_LW;
                dec_legal = (funct3 == 3'b010);
            end
            7'b0100011: begin
                dec_cls   = CLS_SW;
                dec_legal = (funct3 == 3'b010);
            end
            7'b1100011: begin
                dec_cls   = CLS_BR;
                dec_aluop = ALU_SUB;
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Branch condition from the ALU flags of rs1 - rs2.
    always_comb begin
        case (br_f3_q)
            3'b000:  taken = status[4];
            3'b001:  taken = !status[4];
            3'b100:  taken = status[3] ^ status[2];
            3'b101:  taken = !(status[3] ^ status[2]);
            default: taken = 1'b0;
        endcase
    end

    // Main sequencer. Every output register is loaded with the value for the
    // state being entered. Enables default to zero each cycle, so a pulse
    // lasts exactly one state. The first FETCH after reset spends one cycle
    // with ir_we low, so no write enable fires in the cycle after reset. It
    // then raises ir_we and proceeds as a normal FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_R;
            br_f3_q   <= 3'b000;
            nop_q     <= 1'b0;
            alusrc_q  <= 1'b0;
            aluop_q   <= ALU_ADD;
            memrw_q   <= 1'b0;
            wb_q      <= 1'b0;
            regrw_q   <= 1'b0;
            immgen_q  <= IMM_NONE;
            pc_we_q   <= 1'b0;
            ir_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            if (pc_we_q) begin
                instret_q <= instret_q + CNT_W'(1);
            end

            alusrc_q <= 1'b0;
            aluop_q  <= ALU_ADD;
            memrw_q  <= 1'b0;
            wb_q     <= 1'b0;
            regrw_q  <= 1'b0;
            immgen_q <= IMM_NONE;
            pc_we_q  <= 1'b0;
            ir_we_q  <= 1'b0;

            case (state_q)
                ST_FETCH: begin
                    if (ir_we_q) begin
                        state_q <= ST_DECODE;
                    end else begin
                        ir_we_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    cls_q   <= dec_cls;
                    br_f3_q <= funct3;
                    nop_q   <= !dec_legal;
                    if (dec_legal) begin
                        state_q <= ST_EXEC;
                        aluop_q <= dec_aluop;
                        case (dec_cls)
                            CLS_I:  begin alusrc_q <= 1'b1; immgen_q <= IMM_I; end
                            CLS_LW: begin alusrc_q <= 1'b1; immgen_q <= IMM_I; end
                            CLS_SW: begin alusrc_q <= 1'b1; immgen_q <= IMM_S; end
                            CLS_BR: begin immgen_q <= IMM_B; pc_we_q <= 1'b1;  end
                            default: begin end
                        endcase
                    end else if (TRAP_ON_ILLEGAL) begin
                        state_q   <= ST_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                        pc_we_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (nop_q || (cls_q == CLS_BR)) begin
                        state_q <= ST_FETCH;
                        ir_we_q <= 1'b1;
                    end else begin
                        alusrc_q <= alusrc_q;
                        aluop_q  <= aluop_q;
                        immgen_q <= immgen_q;
                        if ((cls_q == CLS_LW) || (cls_q == CLS_SW)) begin
                            state_q <= ST_MEM;
                            memrw_q <= (cls_q == CLS_SW);
                            pc_we_q <= (cls_q == CLS_SW);
                        end else begin
                            state_q <= ST_WB;
                            regrw_q <= 1'b1;
                            wb_q    <= 1'b1;
                            pc_we_q <= 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    if (cls_q == CLS_LW) begin
                        state_q  <= ST_WB;
                        alusrc_q <= alusrc_q;
                        aluop_q  <= aluop_q;
                        immgen_q <= immgen_q;
                        regrw_q  <= 1'b1;
                        pc_we_q  <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                        ir_we_q <= 1'b1;
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                    ir_we_q <= 1'b1;
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign pcsrc       = (state_q == ST_EXEC) && (cls_q == CLS_BR) && !nop_q && taken;
    assign alusrc      = alusrc_q;
    assign aluop       = aluop_q;
    assign memrw       = memrw_q;
    assign wb          = wb_q;
    assign regrw       = regrw_q;
    assign immgen_ctrl = immgen_q;
    assign pc_we       = pc_we_q;
    assign ir_we       = ir_we_q;
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// tb_riscv_ctrl_fsm
// Directed bench for riscv_ctrl_fsm. It drives two instances from the same inputs:
//   dut   : default build, illegal encodings trap, 32-bit counter
//   dut_n : illegal encodings retire as NOP, 3-bit counter (exercises wrap)
// The bench builds each expected output word from a per-instruction table
// entry and the cycle index within the instruction.
module tb_riscv_ctrl_fsm;

    localparam int K_RI = 0;
    localparam int K_LW = 1;
    localparam int K_SW = 2;
    localparam int K_BR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  status;

    logic        pcsrc, alusrc, memrw, wb, regrw, pc_we, ir_we, illegal;
    logic [3:0]  aluop;
    logic [1:0]  immgen_ctrl;
    logic [2:0]  state;
    logic [31:0] instret;

    logic        pcsrc_n, alusrc_n, memrw_n, wb_n, regrw_n, pc_we_n, ir_we_n, illegal_n;
    logic [3:0]  aluop_n;
    logic [1:0]  immgen_ctrl_n;
    logic [2:0]  state_n;
    logic [2:0]  instret_n;

    logic [16:0] act, act_n;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  status;
        int          kind;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [1:0]  immgen;
        logic        taken;
    } vec_t;

    vec_t vecs[21];

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    riscv_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .status(status),
        .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop), .memrw(memrw),
        .wb(wb), .regrw(regrw), .immgen_ctrl(immgen_ctrl), .pc_we(pc_we),
        .ir_we(ir_we), .state(state), .illegal(illegal), .instret(instret)
    );

    riscv_ctrl_fsm #(.CNT_W(3), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .instr(instr), .status(status),
        .pcsrc(pcsrc_n), .alusrc(alusrc_n), .aluop(aluop_n), .memrw(memrw_n),
        .wb(wb_n), .regrw(regrw_n), .immgen_ctrl(immgen_ctrl_n), .pc_we(pc_we_n),
        .ir_we(ir_we_n), .state(state_n), .illegal(illegal_n), .instret(instret_n)
    );

    always #5 clk = ~clk;

    assign act   = {state, pcsrc, alusrc, aluop, memrw, wb, regrw,
                    immgen_ctrl, pc_we, ir_we, illegal};
    assign act_n = {state_n, pcsrc_n, alusrc_n, aluop_n, memrw_n, wb_n, regrw_n,
                    immgen_ctrl_n, pc_we_n, ir_we_n, illegal_n};

    // Packs an expected output word in the same field order as act.
    function automatic logic [16:0] pack(input logic [2:0] st, input logic pc,
                                         input logic as, input logic [3:0] op,
                                         input logic mrw, input logic w,
                                         input logic rrw, input logic [1:0] im,
                                         input logic pcw, input logic irw,
                                         input logic ill);
        return {st, pc, as, op, mrw, w, rrw, im, pcw, irw, ill};
    endfunction

    function automatic int numCycles(input vec_t v);
        case (v.kind)
            K_BR:    return 3;
            K_LW:    return 5;
            default: return 4;
        endcase
    endfunction

    // Expected outputs for cycle c of an instruction that starts in FETCH.
    function automatic logic [16:0] expWord(input vec_t v, input int c);
        logic [16:0] w;
        w = '0;
        case (c)
            0: w = pack(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
            1: w = pack(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            2: w = pack(3'd2, (v.kind == K_BR) ? v.taken : 1'b0, v.alusrc, v.aluop,
                        1'b0, 1'b0, 1'b0, v.immgen, (v.kind == K_BR), 1'b0, 1'b0);
            3: begin
                if (v.kind == K_SW)
                    w = pack(3'd3, 1'b0, v.alusrc, v.aluop, 1'b1, 1'b0, 1'b0, v.immgen, 1'b1, 1'b0, 1'b0);
                else if (v.kind == K_LW)
                    w = pack(3'd3, 1'b0, v.alusrc, v.aluop, 1'b0, 1'b0, 1'b0, v.immgen, 1'b0, 1'b0, 1'b0);
                else
                    w = pack(3'd4, 1'b0, v.alusrc, v.aluop, 1'b0, 1'b1, 1'b1, v.immgen, 1'b1, 1'b0, 1'b0);
            end
            4: w = pack(3'd4, 1'b0, v.alusrc, v.aluop, 1'b0, 1'b0, 1'b1, v.immgen, 1'b1, 1'b0, 1'b0);
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic applyStimulus(input logic [31:0] i, input logic [4:0] s);
        instr  = i;
        status = s;
    endtask

    task automatic checkOutput(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Runs one table entry from a FETCH with ir_we high and checks both DUTs
    // on every cycle, then the retire counters.
    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v.instr, v.status);
        for (int c = 0; c < numCycles(v); c++) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d_c%0d", idx, c), act, expWord(v, c));
            checkOutput($sformatf("v%0d_c%0d_n", idx, c), act_n, expWord(v, c));
            @(posedge clk);
            #1;
        end
        retired++;
        checkCount($sformatf("v%0d_instret", idx), instret, 32'(retired));
        checkCount($sformatf("v%0d_instret_n", idx), {29'b0, instret_n}, 32'(retired % 8));
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired = 0;
    endtask

    initial begin
        //            instr          status    kind  aluop  as    imm    taken
        vecs[0]  = '{32'h002081B3, 5'b00000, K_RI, 4'd0, 1'b0, 2'b00, 1'b0}; // add
        vecs[1]  = '{32'h402081B3, 5'b00000, K_RI, 4'd1, 1'b0, 2'b00, 1'b0}; // sub
        vecs[2]  = '{32'h0080A283, 5'b00000, K_LW, 4'd0, 1'b1, 2'b01, 1'b0}; // lw
        vecs[3]  = '{32'h0050A223, 5'b00000, K_SW, 4'd0, 1'b1, 2'b10, 1'b0}; // sw
        vecs[4]  = '{32'h00208463, 5'b10000, K_BR, 4'd1, 1'b0, 2'b11, 1'b1}; // beq Z=1
        vecs[5]  = '{32'h00208463, 5'b00000, K_BR, 4'd1, 1'b0, 2'b11, 1'b0}; // beq Z=0
        vecs[6]  = '{32'h0020C463, 5'b01000, K_BR, 4'd1, 1'b0, 2'b11, 1'b1}; // blt N=1 V=0
        vecs[7]  = '{32'h0020C463, 5'b01100, K_BR, 4'd1, 1'b0, 2'b11, 1'b0}; // blt N=1 V=1
        vecs[8]  = '{32'h00209463, 5'b00000, K_BR, 4'd1, 1'b0, 2'b11, 1'b1}; // bne Z=0
        vecs[9]  = '{32'h0020D463, 5'b01100, K_BR, 4'd1, 1'b0, 2'b11, 1'b1}; // bge N=1 V=1
        vecs[10] = '{32'h0020D463, 5'b01000, K_BR, 4'd1, 1'b0, 2'b11, 1'b0}; // bge N=1 V=0
        vecs[11] = '{32'h00500093, 5'b00000, K_RI, 4'd0, 1'b1, 2'b01, 1'b0}; // addi 5
        vecs[12] = '{32'hFFF00093, 5'b00000, K_RI, 4'd0, 1'b1, 2'b01, 1'b0}; // addi -1
        vecs[13] = '{32'h40315093, 5'b00000, K_RI, 4'd7, 1'b1, 2'b01, 1'b0}; // srai
        vecs[14] = '{32'h0020C1B3, 5'b00000, K_RI, 4'd4, 1'b0, 2'b00, 1'b0}; // xor
        vecs[15] = '{32'h0020B1B3, 5'b00000, K_RI, 4'd9, 1'b0, 2'b00, 1'b0}; // sltu
        vecs[16] = '{32'h00502093, 5'b00000, K_RI, 4'd8, 1'b1, 2'b01, 1'b0}; // slti
        vecs[17] = '{32'h0020E1B3, 5'b00000, K_RI, 4'd3, 1'b0, 2'b00, 1'b0}; // or
        vecs[18] = '{32'h0020F1B3, 5'b00000, K_RI, 4'd2, 1'b0, 2'b00, 1'b0}; // and
        vecs[19] = '{32'h002091B3, 5'b00000, K_RI, 4'd5, 1'b0, 2'b00, 1'b0}; // sll
        vecs[20] = '{32'h0020D1B3, 5'b00000, K_RI, 4'd6, 1'b0, 2'b00, 1'b0}; // srl

        applyStimulus(32'h0, 5'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cycle after reset: FETCH with every output low.
        @(negedge clk);
        checkOutput("reset_word", act, 17'h0);
        checkOutput("reset_word_n", act_n, 17'h0);
        checkCount("reset_instret", instret, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            runVector(vecs[i], i);
        end

        // Illegal word: dut traps and stays there, dut_n retires a NOP.
        applyStimulus(32'hFFFFFFFF, 5'b0);
        @(negedge clk);
        checkOutput("ill_fetch", act, pack(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        checkOutput("ill_decode", act, pack(3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        checkOutput("nop_exec_n", act_n, pack(3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("trap_c%0d", c), act, pack(3'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
            if (c == 0) begin
                @(negedge clk);
                checkOutput("nop_refetch_n", act_n, pack(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
                checkCount("nop_instret_n", {29'b0, instret_n}, 32'((retired + 1) % 8));
            end else begin
                @(negedge clk);
            end
        end
        checkCount("trap_instret", instret, 32'(retired));

        doReset();
        checkOutput("trap_reset", act, 17'h0);
        checkCount("trap_reset_instret", instret, 32'd0);
        checkOutput("trap_reset_n", act_n, 17'h0);
        @(posedge clk);
        #1;

        // SLL with funct7=0100000 is not a legal shift encoding.
        applyStimulus(32'h402091B3, 5'b0);
        repeat (3) @(negedge clk);
        checkOutput("bad_f7_trap", act, pack(3'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        checkOutput("bad_f7_nop_n", act_n, pack(3'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        doReset();
        @(posedge clk);
        #1;

        // Reset arriving while a store sits in MEM.
        runVector(vecs[0], 100);
        applyStimulus(vecs[3].instr, vecs[3].status);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("swrst_c%0d", c), act, expWord(vecs[3], c));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("swrst_after", act, 17'h0);
        checkCount("swrst_instret", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_ctrl_fsm.md
Name: riscv_ctrl_fsm

Overview:
- Multi-cycle control unit sitting directly upstream of the datapath; drives every datapath control input (pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl) from the fetched instruction and the ALU status vector.
- Adds PC and instruction-register write enables so the datapath moves from single-cycle to FETCH/DECODE/EXEC/MEM/WB sequencing.
- Supports R-type ALU, I-type ALU, LW, SW, BEQ/BNE/BLT/BGE; traps on anything else.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TRAP_ON_ILLEGAL, 1, 1 = illegal instruction enters TRAP; 0 = illegal instruction retires as NOP.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction word from ROM (stable while pc_we=0)
- status  in  5  ALU flags: [4]=Z, [3]=N, [2]=V, [1]=C, [0]=P
- pcsrc  out  1  0 = PC+4, 1 = PC+imm
- alusrc  out  1  0 = rs2, 1 = immediate
- aluop  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- memrw  out  1  1 = RAM write, 0 = read
- wb  out  1  writeback select: 0 = RAM data, 1 = ALU result
- regrw  out  1  register file write enable
- immgen_ctrl  out  2  00 none, 01 I, 10 S, 11 B
- pc_we  out  1  PC load enable (one pulse per retired instruction)
- ir_we  out  1  instruction register load enable
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- illegal  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, rst=1 at clk edge): state=FETCH; all control outputs 0; illegal=0; instret=0. rst dominates every state, including mid-MEM/WB; no write enable is asserted in the cycle following reset.
- Outputs not listed for a state are 0. All outputs are Moore, except pcsrc in EXEC-branch, which is combinational from status.
- FETCH: ir_we=1 -> DECODE.
- DECODE: latch class (R/I/LW/SW/BR) and aluop from instr[6:0], funct3, funct7.
  - Legal funct7 values are 0000000 and 0100000 only; 0100000 is allowed only with ADD/SUB (R) or SRL/SRA.
  - Illegal encoding with TRAP_ON_ILLEGAL=1 -> TRAP. With TRAP_ON_ILLEGAL=0 -> EXEC as NOP (pc_we=1, pcsrc=0, no other writes) -> FETCH.
- EXEC:
  - R-type: alusrc=0, aluop decoded -> WB.
  - I-type: alusrc=1, immgen_ctrl=01; ADDI maps to ADD, never SUB -> WB.
  - LW/SW: alusrc=1, aluop=ADD, immgen_ctrl=01 (LW) or 10 (SW) -> MEM.
  - Branch: alusrc=0, aluop=SUB, immgen_ctrl=11, pc_we=1.
    - Taken conditions: BEQ Z; BNE !Z; BLT N^V; BGE !(N^V).
    - pcsrc=taken; instret++ -> FETCH.
- MEM: address controls held from EXEC.
  - SW: memrw=1, pc_we=1, pcsrc=0, instret++ -> FETCH.
  - LW: memrw=0 -> WB.
- WB: controls held from EXEC; regrw=1; wb=0 for LW, 1 for R/I; pc_we=1, pcsrc=0; instret++ -> FETCH.
- TRAP: illegal=1; all enables 0; held until rst.
- Latency in cycles: branch 3, R/I 4, SW 4, LW 5.
- regrw, memrw and pc_we are each asserted in at most one cycle per instruction; memrw and regrw are never asserted together.
- instret wraps modulo 2^CNT_W with no flag.
- rd=x0 is not special-cased here; register file handles it.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states 0,1,2,4,0; aluop=0000, alusrc=0; regrw=1, wb=1, pc_we=1 only in WB; instret=1.
- sub (0x402081B3) -> aluop=0001; lw x5,8(x1) (0x0080A283) -> MEM with memrw=0, WB with wb=0, regrw=1; total 5 cycles.
- sw x5,4(x1) (0x0050A223) -> immgen_ctrl=10; memrw=1 and pc_we=1 in MEM; regrw never 1; 4 cycles.
- beq (0x00208463): status Z=1 -> pcsrc=1 in EXEC; Z=0 -> pcsrc=0; blt (0x0020C463) with N=1,V=0 -> taken, N=1,V=1 -> not taken.
- instr=0xFFFFFFFF -> TRAP, illegal=1, enables 0 for 10 cycles; rst -> FETCH, illegal=0. Repeat with TRAP_ON_ILLEGAL=0 -> NOP retire, instret++.
- rst asserted during MEM of SW -> next state FETCH, memrw=0 that cycle, instret=0.
